// File: rtl/video_timing_generator.sv
// Runtime-reprogrammable video timing generator.
// Produces pixel coordinates, blanking, polarity-controlled H/V sync and
// line/frame strobes. New timing is validated on request, held pending and
// swapped in only at the last pixel of a frame so a mode change never tears.
module video_timing_generator #(
    parameter int CW           = 12,
    parameter int DEF_H_ACTIVE = 640,
    parameter int DEF_H_FRONT  = 16,
    parameter int DEF_H_SYNC   = 96,
    parameter int DEF_H_BACK   = 48,
    parameter int DEF_V_ACTIVE = 480,
    parameter int DEF_V_FRONT  = 10,
    parameter int DEF_V_SYNC   = 2,
    parameter int DEF_V_BACK   = 33,
    parameter bit DEF_H_POL    = 1'b0,
    parameter bit DEF_V_POL    = 1'b0
) (
    input  logic          in_vga_clk,
    input  logic          in_reset,
    input  logic          in_enable,
    input  logic          in_cfg_valid,
    input  logic [CW-1:0] in_cfg_h_active,
    input  logic [CW-1:0] in_cfg_h_front,
    input  logic [CW-1:0] in_cfg_h_sync,
    input  logic [CW-1:0] in_cfg_h_back,
    input  logic [CW-1:0] in_cfg_v_active,
    input  logic [CW-1:0] in_cfg_v_front,
    input  logic [CW-1:0] in_cfg_v_sync,
    input  logic [CW-1:0] in_cfg_v_back,
    input  logic          in_cfg_h_pol,
    input  logic          in_cfg_v_pol,
    output logic [CW-1:0] out_pixel_x,
    output logic [CW-1:0] out_pixel_y,
    output logic          out_blank_n,
    output logic          out_h_sync,
    output logic          out_v_sync,
    output logic          out_line_start,
    output logic          out_frame_start,
    output logic          out_cfg_pending,
    output logic          out_cfg_ack,
    output logic          out_cfg_err
);
    // Sums of four CW-bit fields need two extra bits to never overflow.
    localparam int SW = CW + 2;
    localparam logic [SW-1:0] MAX_TOTAL = SW'(1) << CW;

    typedef struct packed {
        logic [CW-1:0] h_active;
        logic [CW-1:0] h_front;
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_back;
        logic [CW-1:0] v_active;
        logic [CW-1:0] v_front;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_back;
        logic          h_pol;
        logic          v_pol;
    } timing_t;

    localparam timing_t DEF_TIMING = '{
        h_active: CW'(DEF_H_ACTIVE), h_front: CW'(DEF_H_FRONT),
        h_sync:   CW'(DEF_H_SYNC),   h_back:  CW'(DEF_H_BACK),
        v_active: CW'(DEF_V_ACTIVE), v_front: CW'(DEF_V_FRONT),
        v_sync:   CW'(DEF_V_SYNC),   v_back:  CW'(DEF_V_BACK),
        h_pol:    DEF_H_POL,         v_pol:   DEF_V_POL
    };

    function automatic logic [SW-1:0] sum4(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c, input logic [CW-1:0] d);
        return SW'(a) + SW'(b) + SW'(c) + SW'(d);
    endfunction

    timing_t       cur_reg;
    timing_t       pend_reg;
    timing_t       cfg_in;
    logic          pending_reg;
    logic          applied_reg;
    logic [CW-1:0] h_count_reg;
    logic [CW-1:0] v_count_reg;

    logic [SW-1:0] h_total, v_total, cfg_h_total, cfg_v_total;
    logic [SW-1:0] h_sync_start, v_sync_start;
    logic          cfg_ok, h_end, v_end, apply;
    logic          h_vis, v_vis, h_sync_on, v_sync_on;

    assign cfg_in = '{
        h_active: in_cfg_h_active, h_front: in_cfg_h_front,
        h_sync:   in_cfg_h_sync,   h_back:  in_cfg_h_back,
        v_active: in_cfg_v_active, v_front: in_cfg_v_front,
        v_sync:   in_cfg_v_sync,   v_back:  in_cfg_v_back,
        h_pol:    in_cfg_h_pol,    v_pol:   in_cfg_v_pol
    };

    assign cfg_h_total = sum4(in_cfg_h_active, in_cfg_h_front, in_cfg_h_sync, in_cfg_h_back);
    assign cfg_v_total = sum4(in_cfg_v_active, in_cfg_v_front, in_cfg_v_sync, in_cfg_v_back);
    assign cfg_ok = (in_cfg_h_active != '0) && (in_cfg_h_sync != '0) &&
                    (in_cfg_v_active != '0) && (in_cfg_v_sync != '0) &&
                    (cfg_h_total <= MAX_TOTAL) && (cfg_v_total <= MAX_TOTAL);

    assign h_total      = sum4(cur_reg.h_active, cur_reg.h_front, cur_reg.h_sync, cur_reg.h_back);
    assign v_total      = sum4(cur_reg.v_active, cur_reg.v_front, cur_reg.v_sync, cur_reg.v_back);
    assign h_sync_start = SW'(cur_reg.h_active) + SW'(cur_reg.h_front);
    assign v_sync_start = SW'(cur_reg.v_active) + SW'(cur_reg.v_front);

    assign h_end = (SW'(h_count_reg) == h_total - SW'(1));
    assign v_end = (SW'(v_count_reg) == v_total - SW'(1));
    // Swap timing only on the very last pixel of a frame.
    assign apply = in_enable && pending_reg && h_end && v_end;

    assign h_vis     = SW'(h_count_reg) < SW'(cur_reg.h_active);
    assign v_vis     = SW'(v_count_reg) < SW'(cur_reg.v_active);
    assign h_sync_on = (SW'(h_count_reg) >= h_sync_start) &&
                       (SW'(h_count_reg) < h_sync_start + SW'(cur_reg.h_sync));
    assign v_sync_on = (SW'(v_count_reg) >= v_sync_start) &&
                       (SW'(v_count_reg) < v_sync_start + SW'(cur_reg.v_sync));

    assign out_cfg_pending = pending_reg;

    // Config capture (latest request wins) and frame-boundary apply.
    always_ff @(posedge in_vga_clk or posedge in_reset) begin
        if (in_reset) begin
            cur_reg     <= DEF_TIMING;
            pend_reg    <= DEF_TIMING;
            pending_reg <= 1'b0;
            out_cfg_err <= 1'b0;
        end else begin
            out_cfg_err <= in_cfg_valid && !cfg_ok;
            if (apply) begin
                cur_reg <= pend_reg;
            end
            if (in_cfg_valid && cfg_ok) begin
                pend_reg    <= cfg_in;
                pending_reg <= 1'b1;
            end else if (apply) begin
                pending_reg <= 1'b0;
            end
        end
    end

    // Horizontal/vertical position counters, frozen while disabled.
    always_ff @(posedge in_vga_clk or posedge in_reset) begin
        if (in_reset) begin
            h_count_reg <= '0;
            v_count_reg <= '0;
        end else if (in_enable) begin
            if (h_end) begin
                h_count_reg <= '0;
                v_count_reg <= v_end ? '0 : v_count_reg + 1'b1;
            end else begin
                h_count_reg <= h_count_reg + 1'b1;
            end
        end
    end

    // Registered decode of the current counter state; strobes drop while disabled.
    always_ff @(posedge in_vga_clk or posedge in_reset) begin
        if (in_reset) begin
            out_pixel_x     <= '0;
            out_pixel_y     <= '0;
            out_blank_n     <= 1'b0;
            out_h_sync      <= ~DEF_H_POL;
            out_v_sync      <= ~DEF_V_POL;
            out_line_start  <= 1'b0;
            out_frame_start <= 1'b0;
            out_cfg_ack     <= 1'b0;
            applied_reg     <= 1'b0;
        end else if (in_enable) begin
            out_pixel_x     <= (h_vis && v_vis) ? h_count_reg : '0;
            out_pixel_y     <= (h_vis && v_vis) ? v_count_reg : '0;
            out_blank_n     <= h_vis && v_vis;
            out_h_sync      <= h_sync_on ? cur_reg.h_pol : ~cur_reg.h_pol;
            out_v_sync      <= v_sync_on ? cur_reg.v_pol : ~cur_reg.v_pol;
            out_line_start  <= (h_count_reg == '0);
            out_frame_start <= (h_count_reg == '0) && (v_count_reg == '0);
            // Ack lines up with the frame_start of the first frame in the new mode.
            out_cfg_ack     <= applied_reg;
            applied_reg     <= apply;
        end else begin
            out_line_start  <= 1'b0;
            out_frame_start <= 1'b0;
            out_cfg_ack     <= 1'b0;
        end
    end

endmodule
